// File: rtl/sr_alu_arb.sv
// sr_alu_arb: two-port valid/ready arbiter in front of one shared sr_alu.
// Round-robin grant when both requesters are valid, single registered
// response slot tagged with the requester id, sticky KSLL8 saturation flag.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid[1:0]           requester i presents an operation
//   req_ready[1:0]           requester i accepted this cycle (one-hot or zero)
//   req{0,1}_src_a/src_b     32-bit operands
//   req{0,1}_oper            3-bit ALU operation code
//   resp_valid/resp_ready    response slot handshake
//   resp_id                  requester that issued the held response
//   resp_result/resp_zero    ALU result and zero flag
//   resp_ov                  KSLL8 saturation indicator (0 for other ops)
//   sat_flag/sat_clr         sticky saturation flag and its clear

package sr_cpu_pkg;
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_SRL   = 3'b010;
    localparam logic [2:0] ALU_SLTU  = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_KSLL8 = 3'b101;

    typedef struct packed {
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [2:0]  oper;
    } alu_req_t;
endpackage

// One signed byte lane of KSLL8: shift left, saturate to the int8 range.
module sr_ksll8_lane #(
    parameter int VEC_W = 8
) (
    input  logic [VEC_W-1:0] a,
    input  logic [2:0]       sh,
    output logic [VEC_W-1:0] y,
    output logic             ov
);
    logic [2*VEC_W-1:0] wide;
    logic [VEC_W:0]     top;

    assign wide = {{VEC_W{a[VEC_W-1]}}, a} << sh;
    // Result fits iff everything above the new sign bit is a sign copy.
    assign top  = wide[2*VEC_W-1:VEC_W-1];
    assign ov   = !((&top) || !(|top));
    assign y    = ov ? (a[VEC_W-1] ? {1'b1, {(VEC_W-1){1'b0}}}
                                   : {1'b0, {(VEC_W-1){1'b1}}})
                     : wide[VEC_W-1:0];
endmodule

module sr_alu #(
    parameter int NUM_LANES = 4,
    parameter int VEC_W     = 8
) (
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [2:0]  oper,
    output logic [31:0] result,
    output logic        zero,
    output logic        ov
);
    import sr_cpu_pkg::*;

    logic [NUM_LANES-1:0][VEC_W-1:0] lane_a, lane_y;
    logic [NUM_LANES-1:0]            lane_ov;
    logic [31:0]                     sum, diff;

    assign lane_a = src_a;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            sr_ksll8_lane #(.VEC_W(VEC_W)) u_lane (
                .a  (lane_a[gi]),
                .sh (src_b[2:0]),
                .y  (lane_y[gi]),
                .ov (lane_ov[gi])
            );
        end
    endgenerate

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    // ov is also raised for signed add/sub overflow; the arbiter masks it.
    always_comb begin
        result = '0;
        ov     = 1'b0;
        case (oper)
            ALU_ADD: begin
                result = sum;
                ov     = (src_a[31] == src_b[31]) && (sum[31] != src_a[31]);
            end
            ALU_OR:   result = src_a | src_b;
            ALU_SRL:  result = src_a >> src_b[4:0];
            ALU_SLTU: result = {31'b0, src_a < src_b};
            ALU_SUB: begin
                result = diff;
                ov     = (src_a[31] != src_b[31]) && (diff[31] != src_a[31]);
            end
            ALU_KSLL8: begin
                result = lane_y;
                ov     = |lane_ov;
            end
            default: ;
        endcase
    end

    assign zero = (result == 32'b0);
endmodule

module sr_alu_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_src_a,
    input  logic [31:0] req0_src_b,
    input  logic [2:0]  req0_oper,
    input  logic [31:0] req1_src_a,
    input  logic [31:0] req1_src_b,
    input  logic [2:0]  req1_oper,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic        resp_zero,
    output logic        resp_ov,
    output logic        sat_flag,
    input  logic        sat_clr
);
    import sr_cpu_pkg::*;

    alu_req_t    req0, req1, sel;
    logic        free, xfer, rr;
    logic [1:0]  grant;
    logic [31:0] alu_result;
    logic        alu_zero, alu_ov, sat_hit;

    assign req0 = '{src_a: req0_src_a, src_b: req0_src_b, oper: req0_oper};
    assign req1 = '{src_a: req1_src_a, src_b: req1_src_b, oper: req1_oper};

    assign free = !resp_valid || resp_ready;

    always_comb begin
        grant = 2'b00;
        if (free) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;
    // With no grant the mux still feeds req0; nothing is registered then.
    assign sel       = grant[1] ? req1 : req0;

    sr_alu u_alu (
        .src_a  (sel.src_a),
        .src_b  (sel.src_b),
        .oper   (sel.oper),
        .result (alu_result),
        .zero   (alu_zero),
        .ov     (alu_ov)
    );

    assign sat_hit = (sel.oper == ALU_KSLL8) && alu_ov;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_ov     <= 1'b0;
            rr          <= 1'b0;
        end else if (xfer) begin
            resp_valid  <= 1'b1;
            resp_id     <= grant[1];
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            resp_ov     <= sat_hit;
            rr          <= !grant[1];
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_flag <= 1'b0;
        else if (xfer && sat_hit)
            sat_flag <= 1'b1;
        else if (sat_clr)
            sat_flag <= 1'b0;
    end
endmodule

// File: doc/sr_alu_arb.md
# sr_alu_arb

Two-port arbiter and result stage for the shared schoolRISCV ALU (`sr_alu`, one instance inside this block). It lets the core execute path and a secondary requester (e.g. debug or coprocessor port) share one ALU. It uses valid/ready handshakes and round-robin grant. Results go out through a single registered response slot tagged with the requester ID. The block also keeps a sticky saturation flag (vxsat-style) that is set by any accepted `ALU_KSLL8` operation that saturates.

## Interface
Parameters:
- none (data width fixed at 32, operation code 3 bits, encodings from `sr_cpu.svh`)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: requester i's operation is accepted this cycle
- req0_src_a, req0_src_b  in  32 each  requester 0 operands
- req0_oper  in  3  requester 0 ALU operation code
- req1_src_a, req1_src_b  in  32 each  requester 1 operands
- req1_oper  in  3  requester 1 ALU operation code
- resp_valid  out  1  response slot holds a result
- resp_ready  in  1  consumer takes the response this cycle
- resp_id  out  1  index of the requester that issued the response
- resp_result  out  32  ALU result
- resp_zero  out  1  ALU zero flag for resp_result
- resp_ov  out  1  saturation indicator; only meaningful for `ALU_KSLL8`, forced 0 for all other operations
- sat_flag  out  1  sticky saturation flag
- sat_clr  in  1  clears sat_flag

## Operation
- Slot free condition: `free = !resp_valid || resp_ready`.
- Grant (combinational):
  - If `free` is 0, no grant.
  - If exactly one req_valid bit is set, that requester is granted.
  - If both are set, the requester selected by the round-robin pointer `rr` is granted.
- `req_ready = grant` (one-hot or zero). A transfer occurs when `req_valid[i] && req_ready[i]`.
- The granted requester's operands and oper are muxed into the single `sr_alu` instance.
- Transfer on requester i at a clock edge:
  - resp_valid ← 1, resp_id ← i.
  - resp_result and resp_zero ← ALU outputs.
  - resp_ov ← ALU ov if oper == `ALU_KSLL8`, else 0. The raw ALU ov is never registered for other operations.
  - rr ← the other requester (1 − i).
- No transfer while the consumer drains (resp_valid && resp_ready): resp_valid ← 0. Data registers hold their values.
- resp_valid && !resp_ready: all response registers hold; req_ready = 0.
- The rr pointer changes only on a transfer. It is not affected by cycles where only one requester is valid without a grant.
- Requester rule: once req_valid[i] is asserted, the requester holds it and the operand/oper inputs stable until accepted. The arbiter never revokes a grant within a cycle.
- sat_flag updates at each edge:
  - Set by a transfer with oper == `ALU_KSLL8` and ALU ov == 1.
  - Otherwise cleared by sat_clr.
  - Set wins when both happen in the same cycle.
- `ALU_KSLL8` with srcB[2:0] == 0 is a pass-through: resp_ov = 0 and sat_flag is unchanged.

## Timing
- Reset values: resp_valid 0, resp_id 0, resp_result 0, resp_zero 0, resp_ov 0, sat_flag 0, rr 0 (requester 0 has priority first).
- Reset mid-operation discards any pending response immediately (asynchronous). The first grant after reset release follows the rr = 0 rule.
- Latency: the response is visible the cycle after acceptance.
- Throughput: one operation per cycle with resp_ready held high, alternating between requesters when both are valid.
- Combinational paths:
  - req_valid, resp_ready, resp_valid → req_ready.
  - Operands → ALU → response registers; there is no input→output combinational path on resp_*.
- With both requesters continuously valid, each receives a grant at least every second transfer (no starvation).

## Test plan
- Single op: req0 valid, ADD 0x0000_0005 + 0xFFFF_FFFB, resp_ready = 1.
  - Required: req_ready = 2'b01 in that cycle.
  - Next cycle: resp_valid = 1, resp_id = 0, resp_result = 0, resp_zero = 1, resp_ov = 0.
- KSLL8 saturation: req1 valid, KSLL8, srcA = 0x4001_FF80, srcB = 1.
  - Required: resp_id = 1, resp_result = 0x7F02_FE80, resp_ov = 1, sat_flag = 1 next cycle.
  - sat_clr pulsed later clears sat_flag to 0.
- Contention: both requesters valid for 4 cycles after reset, resp_ready = 1.
  - Required: grants 01, 10, 01, 10; resp_id sequence 0, 1, 0, 1.
- Backpressure: resp_ready = 0 with a response held and both requesters valid.
  - Required: req_ready = 00 and resp_* stable for 3 cycles.
  - On resp_ready = 1, the stored response is consumed and a new grant issues in the same cycle.
- Flag priority/masking:
  - SUB 1 − 2 (result 0xFFFF_FFFF): required resp_ov = 0 and sat_flag unchanged.
  - Saturating KSLL8 accepted in the same cycle as sat_clr: required sat_flag = 1.
- Reset mid-flight: assert rst while resp_valid = 1.
  - Required: resp_valid drops to 0 immediately and sat_flag = 0.
  - After release, requester 0 wins the first two-way contention.
